// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation core.
//   W            default operand width (message, exponent, modulus, result)
//   rsa_state_t  top-level FSM state encoding
//   modmul_hs_t  go/rdy handshake pair between the FSM and the modular multiplier
package rsa_pkg;

    localparam int W = 128;

    // SCAN is only entered when RSA_SKIP_LEADING_ZEROS_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SQR    = 3'd2,
        MUL    = 3'd3,
        DONE   = 3'd4,
        SCAN   = 3'd5
    } rsa_state_t;

    typedef struct packed {
        logic go;
        logic rdy;
    } modmul_hs_t;

endpackage

// File: rtl/rsa_modexp_enc_if.sv
// Operation interface of rsa_modexp_enc.
//   start      launch request (a 0->1 edge starts one operation)
//   message    base m, sampled at launch
//   e_key      exponent (e or d), sampled at launch
//   n          modulus, sampled at launch
//   c          result, stable while done is high
//   done       level, high while c is valid
//   fsm_state  current FSM state, for observation only
// Handshake: a launch happens on the first cycle start is seen high after
// being low, and only while the core is IDLE or DONE; done drops on the cycle
// after launch and rises together with the new c.
interface rsa_modexp_enc_if
    import rsa_pkg::*;
#(
    parameter int W = rsa_pkg::W
);
    logic             start;
    logic [W-1:0]     message;
    logic [W-1:0]     e_key;
    logic [W-1:0]     n;
    logic [W-1:0]     c;
    logic             done;
    rsa_state_t       fsm_state;

    modport master (
        output start, message, e_key, n,
        input  c, done, fsm_state
    );

    modport slave (
        input  start, message, e_key, n,
        output c, done, fsm_state
    );
endinterface

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = (x * y) mod n, with y < n.
// One go cycle loads the operands, then W shift/add/subtract steps run MSB
// first over x. rdy is high during the last step with p valid in that cycle,
// so one product takes W+1 cycles from go.
//   clk, reset  clock, asynchronous active-low reset
//   x, y, n     operands, sampled when go is seen while idle
//   go          start one product
//   p           product, valid while rdy is high
//   rdy         one-cycle completion strobe
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int W = rsa_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] n,
    input  logic         go,
    output logic [W-1:0] p,
    output logic         rdy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  x_sh;
    logic [W-1:0]  y_r;
    logic [W-1:0]  n_r;
    logic [W+1:0]  acc;
    logic [W+1:0]  n_ext;
    logic [W+1:0]  t0;
    logic [W+1:0]  t1;
    logic [W+1:0]  t2;
    logic [CW-1:0] cnt;
    logic          busy;

    // acc < n and y < n keep 2*acc + y below 3n, so two conditional
    // subtractions always bring the sum back under n. W+2 bits hold 3n.
    always_comb begin
        n_ext = {2'b00, n_r};
        t0    = (acc << 1) + (x_sh[W-1] ? {2'b00, y_r} : '0);
        t1    = (t0 >= n_ext) ? (t0 - n_ext) : t0;
        t2    = (t1 >= n_ext) ? (t1 - n_ext) : t1;
    end

    assign p   = t2[W-1:0];
    assign rdy = busy && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_sh <= '0;
            y_r  <= '0;
            n_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (go && !busy) begin
            x_sh <= x;
            y_r  <= y;
            n_r  <= n;
            acc  <= '0;
            cnt  <= CW'(W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= t2;
            x_sh <= x_sh << 1;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/rsa_modexp_enc.sv
// RSA encrypt/decrypt core: c = message^e_key mod n by MSB-first binary
// square-and-multiply, every product through one time-shared rsa_modmul.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset; aborts any running operation
//   bus    rsa_modexp_enc_if.slave (start, message, e_key, n in; c, done, fsm_state out)
// Build option RSA_SKIP_LEADING_ZEROS_EN: when defined, one SCAN cycle after
// REDUCE finds the top set bit of the exponent and the loop starts there
// (e == 0 goes straight to DONE). When undefined every exponent bit is
// processed; leading zeros only square R = 1, so results match.
module rsa_modexp_enc
    import rsa_pkg::*;
#(
    parameter int W = rsa_pkg::W
) (
    input  logic                clk,
    input  logic                reset,
    rsa_modexp_enc_if.slave     bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    rsa_state_t    state, state_nx;
    logic          start_q;
    logic          launch;
    logic [W-1:0]  m_r, e_r, n_r;
    logic [W-1:0]  r_r, r_next;
    logic [W-1:0]  a_r;
    logic [W-1:0]  c_r;
    logic          done_r;
    logic [IW-1:0] bit_idx;
    logic          issued;
    logic          go_c;
    logic [W-1:0]  mm_x, mm_y, mm_p;
    logic          mm_rdy;
    modmul_hs_t    mm_hs;

    assign launch = bus.start && !start_q && ((state == IDLE) || (state == DONE));
    assign mm_hs  = '{go: go_c, rdy: mm_rdy};

`ifdef RSA_SKIP_LEADING_ZEROS_EN
    logic [IW-1:0] msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (e_r[i]) begin
                msb_idx = IW'(i);
            end
        end
    end
`endif

    rsa_modmul #(.W(W)) u_modmul (
        .clk   (clk),
        .reset (reset),
        .x     (mm_x),
        .y     (mm_y),
        .n     (n_r),
        .go    (mm_hs.go),
        .p     (mm_p),
        .rdy   (mm_rdy)
    );

    // Next state, multiplier operand select and the value R takes this cycle.
    // Each product state issues go once (tracked by issued) and leaves on rdy.
    always_comb begin
        state_nx = state;
        go_c     = 1'b0;
        mm_x     = '0;
        mm_y     = '0;
        r_next   = r_r;
        case (state)
            IDLE, DONE: begin
                if (launch) state_nx = REDUCE;
            end
            REDUCE: begin
                mm_x = m_r;
                mm_y = W'(1);
                go_c = !issued;
                if (mm_hs.rdy) begin
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                    state_nx = SCAN;
`else
                    state_nx = SQR;
`endif
                end
            end
            SCAN: begin
                state_nx = (e_r == '0) ? DONE : SQR;
            end
            SQR: begin
                mm_x = r_r;
                mm_y = r_r;
                go_c = !issued;
                if (mm_hs.rdy) begin
                    r_next = mm_p;
                    if (e_r[bit_idx])         state_nx = MUL;
                    else if (bit_idx == '0)   state_nx = DONE;
                    else                      state_nx = SQR;
                end
            end
            MUL: begin
                mm_x = r_r;
                mm_y = a_r;
                go_c = !issued;
                if (mm_hs.rdy) begin
                    r_next   = mm_p;
                    state_nx = (bit_idx == '0) ? DONE : SQR;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            m_r     <= '0;
            e_r     <= '0;
            n_r     <= '0;
            r_r     <= '0;
            a_r     <= '0;
            c_r     <= '0;
            done_r  <= 1'b0;
            bit_idx <= '0;
            issued  <= 1'b0;
        end else begin
            start_q <= bus.start;
            r_r     <= r_next;

            if (go_c)        issued <= 1'b1;
            else if (mm_rdy) issued <= 1'b0;

            if (launch) begin
                m_r     <= bus.message;
                e_r     <= bus.e_key;
                n_r     <= bus.n;
                done_r  <= 1'b0;
                bit_idx <= IW'(W - 1);
                // R starts as 1 mod n so that n == 1 yields 0 even if no
                // product is ever taken.
                r_r     <= (bus.n == W'(1)) ? '0 : W'(1);
            end

            if ((state == REDUCE) && mm_rdy) begin
                a_r <= mm_p;
            end

`ifdef RSA_SKIP_LEADING_ZEROS_EN
            if (state == SCAN) begin
                bit_idx <= msb_idx;
            end
`endif

            // Step to the next bit once this bit's work is finished.
            if ((state == SQR) && mm_rdy && !e_r[bit_idx] && (bit_idx != '0)) begin
                bit_idx <= bit_idx - 1'b1;
            end
            if ((state == MUL) && mm_rdy && (bit_idx != '0)) begin
                bit_idx <= bit_idx - 1'b1;
            end

            // n == 0 has no meaningful residue; the multiplier output is
            // garbage in that case and is masked here.
            if ((state_nx == DONE) && (state != DONE)) begin
                c_r    <= (n_r == '0) ? '0 : r_next;
                done_r <= 1'b1;
            end
        end
    end

    assign bus.c         = c_r;
    assign bus.done      = done_r;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_rsa_modexp_enc.sv
// Testbench for rsa_modexp_enc at W = 16: directed vectors with hand-computed
// results, reset abort, start held high and start pulsed mid-operation, and a
// few random operands against a plain modular-power function.
module tb_rsa_modexp_enc;
    import rsa_pkg::*;

    localparam int TW      = 16;
    localparam int LAT_MAX = (2 * TW + 1) * (TW + 1) + 4;

    logic clk;
    logic rst_n;

    rsa_modexp_enc_if #(.W(TW)) bus ();

    rsa_modexp_enc #(.W(TW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [TW-1:0] exp_q[$];
    int n_checks;
    int n_pass;
    int rises;
    logic done_prev;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && bus.done && !done_prev) begin
            rises = rises + 1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got result %0d, expected none", bus.c);
            end else begin
                chk("result_c", bus.c, exp_q.pop_front());
            end
        end
        done_prev <= bus.done;
    end

    // ---------------- reference ----------------
    function automatic logic [TW-1:0] ref_modpow(input logic [TW-1:0] m, input logic [TW-1:0] e,
                                                 input logic [TW-1:0] nn);
        longint unsigned r, b, md;
        if (nn == 0) return '0;
        md = longint'(nn);
        r  = 1 % md;
        b  = longint'(m) % md;
        for (int i = 0; i < TW; i++) begin
            if (e[i]) r = (r * b) % md;
            b = (b * b) % md;
        end
        return TW'(r);
    endfunction

    // ---------------- driver ----------------
    // pulse_at > 0: pulse start for one cycle that many cycles after launch.
    // hold: keep start high until done and beyond.
    task automatic run_op(input logic [TW-1:0] m, input logic [TW-1:0] e, input logic [TW-1:0] nn,
                          input logic [TW-1:0] expv, input int pulse_at, input bit hold);
        int cyc;
        int rises0;
        @(negedge clk);
        bus.message = m;
        bus.e_key   = e;
        bus.n       = nn;
        bus.start   = 1'b1;
        exp_q.push_back(expv);
        rises0 = rises;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        chk("done_clear_after_launch", TW'(bus.done), TW'(0));
        cyc = 1;
        while (!bus.done && cyc <= LAT_MAX + 8) begin
            @(negedge clk);
            cyc++;
            if (pulse_at > 0 && cyc == pulse_at) bus.start = 1'b1;
            if (pulse_at > 0 && cyc == pulse_at + 1) bus.start = 1'b0;
        end
        n_checks++;
        if (bus.done && cyc <= LAT_MAX) begin
            n_pass++;
        end else begin
            $display("FAIL latency: took %0d cycles (done=%0d), limit %0d", cyc, bus.done, LAT_MAX);
            exp_q.delete();
        end
        @(negedge clk);
        if (hold || pulse_at > 0) begin
            repeat (40) @(negedge clk);
            chk("single_result", TW'(rises - rises0), TW'(1));
            chk("state_done", TW'(bus.fsm_state), TW'(DONE));
            chk("c_held", bus.c, expv);
            bus.start = 1'b0;
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [TW-1:0] rm, re, rn;
        n_checks = 0;
        n_pass   = 0;
        rises    = 0;
        done_prev = 1'b0;
        bus.start   = 1'b0;
        bus.message = '0;
        bus.e_key   = '0;
        bus.n       = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_c", bus.c, TW'(0));
        chk("reset_done", TW'(bus.done), TW'(0));
        chk("reset_state", TW'(bus.fsm_state), TW'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed vectors
        run_op(16'd920,  16'd17,  16'd2773, 16'd948, 0, 1'b0);
        run_op(16'd948,  16'd157, 16'd2773, 16'd920, 0, 1'b0);
        run_op(16'd3693, 16'd17,  16'd2773, 16'd948, 0, 1'b0);
        run_op(16'd3693, 16'd1,   16'd2773, 16'd920, 0, 1'b0);
        run_op(16'd920,  16'd0,   16'd2773, 16'd1,   0, 1'b0);
        run_op(16'd920,  16'd17,  16'd1,    16'd0,   0, 1'b0);
        run_op(16'd920,  16'd0,   16'd1,    16'd0,   0, 1'b0);
        run_op(16'd920,  16'd17,  16'd0,    16'd0,   0, 1'b0);
        run_op(16'd0,    16'd5,   16'd2773, 16'd0,   0, 1'b0);
        run_op(16'd5,    16'd3,   16'd7,    16'd6,   0, 1'b0);
        run_op(16'd2,    16'd65535, 16'd65535, 16'd32768, 0, 1'b0);

        // reset mid-operation
        @(negedge clk);
        bus.message = 16'd920;
        bus.e_key   = 16'd17;
        bus.n       = 16'd2773;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_c", bus.c, TW'(0));
        chk("abort_done", TW'(bus.done), TW'(0));
        chk("abort_state", TW'(bus.fsm_state), TW'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd920, 16'd17, 16'd2773, 16'd948, 0, 1'b0);

        // start held high, then start pulsed mid-operation
        run_op(16'd948, 16'd157, 16'd2773, 16'd920, 0, 1'b1);
        run_op(16'd920, 16'd17,  16'd2773, 16'd948, 60, 1'b0);

        // random operands
        for (int k = 0; k < 6; k++) begin
            rn = TW'($urandom_range(3, 65535)) | 16'd1;
            rm = TW'($urandom_range(0, 65535));
            re = TW'($urandom_range(0, 65535));
            run_op(rm, re, rn, ref_modpow(rm, re, rn), 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", TW'(exp_q.size()), TW'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
